// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// one-hot grant constants and the state-to-grant decode.
package wb_arbiter_2m_pkg;

  localparam int N_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // The grant vector is a pure decode of the state register, so it is glitch-free.
  function automatic logic [1:0] state_to_gnt(input arb_state_e st);
    case (st)
      ST_GNT0: return GNT_M0;
      ST_GNT1: return GNT_M1;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// One Wishbone link (master side drives cyc/stb/we/adr/wdat/sel; slave side
// returns rdat/ack/err).
interface wb_arbiter_2m_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [AW-1:0]     adr;
  logic [DW-1:0]     wdat;
  logic [DW/8-1:0]   sel;
  logic [DW-1:0]     rdat;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, adr, wdat, sel,
    input  rdat, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, wdat, sel,
    output rdat, ack, err
  );

endinterface

// File: rtl/wb_arbiter_2m_watchdog.sv
// Ack watchdog: counts strobe cycles without ack and pulses expire on the
// TIMEOUT-th such cycle. TIMEOUT = 0 disables it.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int            CW   = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;
      logic          expire_w;

      // An ack in the expiry cycle wins, so ack masks the pulse.
      always_comb begin
        expire_w   = stb & ~ack & (count_reg == LAST);
        count_next = count_reg + 1'b1;
        if (clr || !stb || ack || expire_w) begin
          count_next = '0;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end

      assign expire = expire_w;
    end else begin : g_off
      logic unused_wd_inputs;
      assign unused_wd_inputs = &{1'b0, clk_i, rst_i, clr, stb, ack};
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant locked for the
// whole CYC, handshake forwarded to the granted master only, ack watchdog abort.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_arbiter_2m_if.slave        m0,
  wb_arbiter_2m_if.slave        m1,
  wb_arbiter_2m_if.master       s,
  output logic [1:0]            gnt_o
);

  arb_state_e state_reg;
  arb_state_e state_next;
  logic       last_m1_reg;
  logic       last_m1_next;

  logic [N_MASTERS-1:0] m_cyc;
  logic [N_MASTERS-1:0] m_stb;
  logic [N_MASTERS-1:0] m_we;
  logic [AW-1:0]        m_adr  [N_MASTERS];
  logic [DW-1:0]        m_wdat [N_MASTERS];
  logic [DW/8-1:0]      m_sel  [N_MASTERS];

  logic [N_MASTERS-1:0] ack_vec;
  logic [N_MASTERS-1:0] err_vec;
  logic [DW-1:0]        rdat_vec [N_MASTERS];

  logic [1:0]           gnt;
  logic                 g_cyc;
  logic                 g_stb;
  logic                 g_we;
  logic [AW-1:0]        g_adr;
  logic [DW-1:0]        g_wdat;
  logic [DW/8-1:0]      g_sel;
  logic                 s_cyc_gated;
  logic                 s_stb_gated;
  logic                 wd_expire;
  logic                 wd_clr;

  // Gather both masters into arrays so the per-master logic can be generated.
  assign m_cyc     = {m1.cyc, m0.cyc};
  assign m_stb     = {m1.stb, m0.stb};
  assign m_we      = {m1.we,  m0.we};
  assign m_adr[0]  = m0.adr;
  assign m_adr[1]  = m1.adr;
  assign m_wdat[0] = m0.wdat;
  assign m_wdat[1] = m1.wdat;
  assign m_sel[0]  = m0.sel;
  assign m_sel[1]  = m1.sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      last_m1_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      last_m1_reg <= last_m1_next;
    end
  end

  // Grants only leave through IDLE, which guarantees one dead cycle between owners.
  always_comb begin
    state_next   = state_reg;
    last_m1_next = last_m1_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m_cyc[0] && m_cyc[1]) begin
          state_next = last_m1_reg ? ST_GNT0 : ST_GNT1;
        end else if (m_cyc[0]) begin
          state_next = ST_GNT0;
        end else if (m_cyc[1]) begin
          state_next = ST_GNT1;
        end
        if (state_next != ST_IDLE) begin
          last_m1_next = (state_next == ST_GNT1);
        end
      end
      ST_GNT0: if (!m_cyc[0]) state_next = ST_IDLE;
      ST_GNT1: if (!m_cyc[1]) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign gnt   = state_to_gnt(state_reg);
  assign gnt_o = gnt;

  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_adr  = '0;
    g_wdat = '0;
    g_sel  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt[i]) begin
        g_cyc  = m_cyc[i];
        g_stb  = m_stb[i];
        g_we   = m_we[i];
        g_adr  = m_adr[i];
        g_wdat = m_wdat[i];
        g_sel  = m_sel[i];
      end
    end
  end

  assign wd_clr = (state_next != state_reg);

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (wd_clr),
    .stb    (g_stb),
    .ack    (s.ack),
    .expire (wd_expire)
  );

  // The abort cycle withdraws the strobe so a late slave ack can never be forwarded.
  assign s_cyc_gated = g_cyc & ~wd_expire;
  assign s_stb_gated = g_stb & ~wd_expire;

  assign s.cyc  = s_cyc_gated;
  assign s.stb  = s_stb_gated;
  assign s.we   = g_we;
  assign s.adr  = g_adr;
  assign s.wdat = g_wdat;
  assign s.sel  = g_sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign ack_vec[gi]  = s.ack & s_cyc_gated & s_stb_gated & gnt[gi];
      assign err_vec[gi]  = wd_expire & gnt[gi];
      assign rdat_vec[gi] = gnt[gi] ? s.rdat : '0;
    end
  endgenerate

  assign m0.ack  = ack_vec[0];
  assign m0.err  = err_vec[0];
  assign m0.rdat = rdat_vec[0];
  assign m1.ack  = ack_vec[1];
  assign m1.err  = err_vec[1];
  assign m1.rdat = rdat_vec[1];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: grant/round-robin, locked multi-beat, watchdog, reset abort.
module tb_wb_arbiter_2m;

  logic       clk;
  logic       rst;
  logic [1:0] gnt;
  int         checks;
  int         failures;
  int         err_count;

  wb_arbiter_2m_if #(.AW(32), .DW(32)) m0_if ();
  wb_arbiter_2m_if #(.AW(32), .DW(32)) m1_if ();
  wb_arbiter_2m_if #(.AW(32), .DW(32)) s_if ();

  wb_arbiter_2m #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt_o (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int idx, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    if (idx == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
      m0_if.adr = adr; m0_if.wdat = dat; m0_if.sel = 4'hF;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
      m1_if.adr = adr; m1_if.wdat = dat; m1_if.sel = 4'hF;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_if.ack = 1'b0; s_if.rdat = 32'h0; s_if.err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_s_cyc", s_if.cyc, 1'b0);
    check_eq("rst_s_stb", s_if.stb, 1'b0);
    check_eq("rst_m0_ack", m0_if.ack, 1'b0);
    check_eq("rst_m0_err", m0_if.err, 1'b0);

    // 1: single m0 write, slave acks two cycles after grant
    next_cycle();
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
    s_if.rdat = 32'h12345678;
    #1;
    check_eq("t1_gnt_latency", gnt, 2'b00);
    check_eq("t1_s_cyc_pre", s_if.cyc, 1'b0);
    next_cycle(); #1;
    check_eq("t1_gnt", gnt, 2'b01);
    check_eq("t1_s_adr", s_if.adr, 32'h4);
    check_eq("t1_s_dat", s_if.wdat, 32'hDEADBEEF);
    check_eq("t1_s_we", s_if.we, 1'b1);
    check_eq("t1_s_stb", s_if.stb, 1'b1);
    check_eq("t1_m0_ack_wait0", m0_if.ack, 1'b0);
    next_cycle(); #1;
    check_eq("t1_m0_ack_wait1", m0_if.ack, 1'b0);
    next_cycle();
    s_if.ack = 1'b1;
    #1;
    check_eq("t1_m0_ack", m0_if.ack, 1'b1);
    check_eq("t1_m0_dat", m0_if.rdat, 32'h12345678);
    check_eq("t1_m1_ack", m1_if.ack, 1'b0);
    check_eq("t1_m1_dat", m1_if.rdat, 32'h0);
    check_eq("t1_m1_err", m1_if.err, 1'b0);
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("t1_m0_ack_once", m0_if.ack, 1'b0);
    check_eq("t1_gnt_hold", gnt, 2'b01);
    next_cycle(); #1;
    check_eq("t1_gnt_release", gnt, 2'b00);

    // 2: tie after reset goes to m0, then m1, then m0 again
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    #1;
    check_eq("t2_gnt_idle", gnt, 2'b00);
    next_cycle();
    s_if.ack = 1'b1;
    #1;
    check_eq("t2_gnt_m0_first", gnt, 2'b01);
    check_eq("t2_s_adr_m0", s_if.adr, 32'h20);
    check_eq("t2_m0_ack", m0_if.ack, 1'b1);
    check_eq("t2_m1_ack_blocked", m1_if.ack, 1'b0);
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("t2_gnt_hold", gnt, 2'b01);
    next_cycle(); #1;
    check_eq("t2_gnt_gap", gnt, 2'b00);
    next_cycle();
    s_if.ack = 1'b1;
    #1;
    check_eq("t2_gnt_m1", gnt, 2'b10);
    check_eq("t2_s_adr_m1", s_if.adr, 32'h30);
    check_eq("t2_m1_ack", m1_if.ack, 1'b1);
    check_eq("t2_m0_ack_off", m0_if.ack, 1'b0);
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    next_cycle();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
    #1;
    check_eq("t2_gnt_idle2", gnt, 2'b00);
    next_cycle(); #1;
    check_eq("t2_tie2_m0", gnt, 2'b01);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle(); #1;
    check_eq("t2_gnt_end", gnt, 2'b00);

    // 3: m1 locked over three beats while m0 waits
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA1);
    next_cycle();
    s_if.ack = 1'b1;
    #1;
    check_eq("t3_gnt_b1", gnt, 2'b10);
    check_eq("t3_m1_ack_b1", m1_if.ack, 1'b1);
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'hA2);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    check_eq("t3_gnt_locked", gnt, 2'b10);
    check_eq("t3_s_adr_m1", s_if.adr, 32'h14);
    next_cycle();
    s_if.ack = 1'b1;
    #1;
    check_eq("t3_gnt_b2", gnt, 2'b10);
    check_eq("t3_m1_ack_b2", m1_if.ack, 1'b1);
    check_eq("t3_m0_ack_b2", m0_if.ack, 1'b0);
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h18, 32'hA3);
    next_cycle();
    s_if.ack = 1'b1;
    #1;
    check_eq("t3_gnt_b3", gnt, 2'b10);
    check_eq("t3_m1_ack_b3", m1_if.ack, 1'b1);
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("t3_gnt_hold", gnt, 2'b10);
    next_cycle(); #1;
    check_eq("t3_gnt_gap", gnt, 2'b00);
    next_cycle(); #1;
    check_eq("t3_gnt_m0", gnt, 2'b01);
    check_eq("t3_s_adr_m0", s_if.adr, 32'h40);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle(); #1;
    check_eq("t3_gnt_end", gnt, 2'b00);

    // 4: slave never acks, watchdog aborts on the 8th strobe cycle
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    err_count = 0;
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 9) begin
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_if.ack = 1'b1;
      end
      #1;
      if (m0_if.err) err_count++;
      if (k < 8) begin
        check_eq($sformatf("t4_err_c%0d", k), m0_if.err, 1'b0);
      end else if (k == 8) begin
        check_eq("t4_err_c8", m0_if.err, 1'b1);
        check_eq("t4_s_stb_abort", s_if.stb, 1'b0);
        check_eq("t4_s_cyc_abort", s_if.cyc, 1'b0);
        check_eq("t4_m1_err", m1_if.err, 1'b0);
      end else begin
        check_eq("t4_late_ack_dropped", m0_if.ack, 1'b0);
        check_eq("t4_err_c9", m0_if.err, 1'b0);
      end
    end
    check_eq("t4_err_pulses", err_count, 1);
    next_cycle();
    s_if.ack = 1'b0;
    #1;
    check_eq("t4_gnt_end", gnt, 2'b00);

    // 5: ack lands on the expiry cycle and wins
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h54, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 8) s_if.ack = 1'b1;
      #1;
      if (k == 7) check_eq("t5_err_c7", m0_if.err, 1'b0);
      if (k == 8) begin
        check_eq("t5_ack_wins", m0_if.ack, 1'b1);
        check_eq("t5_no_err", m0_if.err, 1'b0);
        check_eq("t5_s_stb", s_if.stb, 1'b1);
      end
    end
    next_cycle();
    s_if.ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle(); #1;
    check_eq("t5_gnt_end", gnt, 2'b00);

    // 6: reset while m1 granted drops the transfer; first tie afterwards to m0
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h60, 32'h77);
    next_cycle(); #1;
    check_eq("t6_gnt_m1", gnt, 2'b10);
    check_eq("t6_s_stb", s_if.stb, 1'b1);
    next_cycle();
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h70, 32'h0);
    #1;
    check_eq("t6_sync_rst_gnt", gnt, 2'b10);
    next_cycle();
    rst = 1'b0;
    s_if.ack = 1'b1;
    #1;
    check_eq("t6_gnt_rst", gnt, 2'b00);
    check_eq("t6_s_cyc_rst", s_if.cyc, 1'b0);
    check_eq("t6_m0_ack_rst", m0_if.ack, 1'b0);
    check_eq("t6_m1_ack_rst", m1_if.ack, 1'b0);
    check_eq("t6_m0_err_rst", m0_if.err, 1'b0);
    check_eq("t6_m1_err_rst", m1_if.err, 1'b0);
    next_cycle();
    s_if.ack = 1'b0;
    #1;
    check_eq("t6_tie_m0", gnt, 2'b01);
    check_eq("t6_s_adr_m0", s_if.adr, 32'h70);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
